// File: rtl/mel_frame_scheduler.sv
// mel_frame_scheduler
//   Sequences one mel-filterbank frame:
//   FILL  - accept NRFFT power-spectrum beats and stream them into the mel buffer.
//   START - pulse mel_start_o and invalidate the energy buffer.
//   WAIT  - capture mel energies until mel_done_i, or abort after TIMEOUT cycles.
//   DRAIN - stream NUM_FILTERS energies out on the m_* handshake.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  spectrum input stream
//   mel_in_valid_o/mel_ptr_o/mel_data_o  write port into the mel buffer
//   mel_start_o, mel_done_i     mel computation start pulse / completion
//   mel_valid_i/mel_value_i/mel_ptr_i    mel energy capture port
//   m_valid/m_ready/m_data/m_idx/m_last  energy output stream
//   busy_o                      high outside FILL
//   err_o, err_clr_i            sticky framing/timeout error and its clear
//   frame_cnt_o                 completed-frame counter (wraps)
module mel_frame_scheduler #(
    parameter int unsigned NUM_FILTERS  = 40,
    parameter int unsigned NRFFT        = 257,
    parameter int unsigned INPUT_WIDTH  = 32,
    parameter int unsigned OUTPUT_WIDTH = 8,
    parameter int unsigned TIMEOUT      = 16384
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [INPUT_WIDTH-1:0]         s_data,
    input  logic                           s_last,
    output logic                           mel_in_valid_o,
    output logic [$clog2(NRFFT)-1:0]       mel_ptr_o,
    output logic [INPUT_WIDTH-1:0]         mel_data_o,
    output logic                           mel_start_o,
    input  logic                           mel_done_i,
    input  logic                           mel_valid_i,
    input  logic [OUTPUT_WIDTH-1:0]        mel_value_i,
    input  logic [$clog2(NUM_FILTERS)-1:0] mel_ptr_i,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [OUTPUT_WIDTH-1:0]        m_data,
    output logic [$clog2(NUM_FILTERS)-1:0] m_idx,
    output logic                           m_last,
    output logic                           busy_o,
    output logic                           err_o,
    input  logic                           err_clr_i,
    output logic [15:0]                    frame_cnt_o
);

    localparam int unsigned PW = $clog2(NRFFT);
    localparam int unsigned FW = $clog2(NUM_FILTERS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           beat_q, beat_d;
    logic [TW-1:0]           wait_q, wait_d;
    logic [FW-1:0]           drain_q, drain_d;
    logic [15:0]             frames_q, frames_d;
    logic                    err_q, err_d;
    logic                    s_ready_q;
    logic [NUM_FILTERS-1:0]  vld_q, vld_d;
    logic [OUTPUT_WIDTH-1:0] energy_q [NUM_FILTERS];

    logic s_hs;
    logic cap;

    assign s_hs = s_valid & s_ready_q;
    assign cap  = (state_q == WAIT) && mel_valid_i && (32'(mel_ptr_i) < NUM_FILTERS);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        drain_d  = drain_q;
        frames_d = frames_q;
        vld_d    = vld_q;
        // Clear first so any set below overrides a coincident clear.
        err_d    = err_clr_i ? 1'b0 : err_q;

        if (cap) begin
            vld_d[mel_ptr_i] = 1'b1;
        end

        case (state_q)
            FILL: begin
                if (s_hs) begin
                    if (beat_q == PW'(NRFFT - 1)) begin
                        beat_d  = '0;
                        state_d = START;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Short frame: drop it and restart bin numbering.
                        beat_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            START: begin
                vld_d   = '0;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mel_done_i) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = FILL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (drain_q == FW'(NUM_FILTERS - 1)) begin
                        drain_d  = '0;
                        frames_d = frames_q + 16'd1;
                        state_d  = FILL;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            beat_q    <= '0;
            wait_q    <= '0;
            drain_q   <= '0;
            frames_q  <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            drain_q   <= drain_d;
            frames_q  <= frames_d;
            err_q     <= err_d;
            s_ready_q <= (state_d == FILL);
            vld_q     <= vld_d;
        end
    end

    // Energy storage carries no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (cap) begin
            energy_q[mel_ptr_i] <= mel_value_i;
        end
    end

    assign s_ready        = s_ready_q;
    assign mel_in_valid_o = s_hs;
    assign mel_ptr_o      = beat_q;
    assign mel_data_o     = s_hs ? s_data : '0;
    assign mel_start_o    = (state_q == START);
    assign m_valid        = (state_q == DRAIN);
    assign m_idx          = drain_q;
    // Filters never written this frame read as zero rather than stale data.
    assign m_data         = (m_valid && vld_q[drain_q]) ? energy_q[drain_q] : '0;
    assign m_last         = m_valid && (drain_q == FW'(NUM_FILTERS - 1));
    assign busy_o         = (state_q != FILL);
    assign err_o          = err_q;
    assign frame_cnt_o    = frames_q;

endmodule

// File: tb/tb_mel_frame_scheduler.sv
module tb_mel_frame_scheduler;

    localparam int NF = 40;
    localparam int NB = 257;
    localparam int TO = 1000;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        mel_in_valid_o;
    logic [8:0]  mel_ptr_o;
    logic [31:0] mel_data_o;
    logic        mel_start_o;
    logic        mel_done_i;
    logic        mel_valid_i;
    logic [7:0]  mel_value_i;
    logic [5:0]  mel_ptr_i;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [5:0]  m_idx;
    logic        m_last;
    logic        busy_o;
    logic        err_o;
    logic        err_clr_i;
    logic [15:0] frame_cnt_o;

    mel_frame_scheduler #(
        .NUM_FILTERS (NF),
        .NRFFT       (NB),
        .INPUT_WIDTH (32),
        .OUTPUT_WIDTH(8),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .mel_in_valid_o(mel_in_valid_o),
        .mel_ptr_o     (mel_ptr_o),
        .mel_data_o    (mel_data_o),
        .mel_start_o   (mel_start_o),
        .mel_done_i    (mel_done_i),
        .mel_valid_i   (mel_valid_i),
        .mel_value_i   (mel_value_i),
        .mel_ptr_i     (mel_ptr_i),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_idx         (m_idx),
        .m_last        (m_last),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i),
        .frame_cnt_o   (frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ptr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic [5:0] idx;
        logic       last;
    } en_t;

    wr_t wr_q[$];
    en_t exp_q[$];

    int n_tests     = 0;
    int n_fail      = 0;
    int start_cnt   = 0;
    int exp_starts  = 0;
    int frames_model = 0;
    int eng_mode    = 0;   // 0 ordered, 1 random + done with last write, 2 random + late done, 3 silent
    int rdy_mode    = 0;   // 0 random m_ready, 1 always ready
    bit stray_en    = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream back-pressure.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Mel engine model: builds the expected energy vector from its own writes.
    task automatic run_engine();
        logic [7:0] model [NF];
        int         idx;
        logic [7:0] val;
        logic       coinc;
        mel_valid_i = 1'b0;
        mel_done_i  = 1'b0;
        if (eng_mode == 3) begin
            for (int c = 0; c < TO + 50; c++) begin
                @(negedge clk);
                if (!busy_o) break;
            end
            return;
        end
        coinc = (eng_mode == 1);
        for (int k = 0; k < NF; k++) model[k] = '0;
        for (int i = 0; i < NF; i++) begin
            if (eng_mode != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                    mel_valid_i = 1'b1;
                    mel_done_i  = 1'b0;
                    mel_ptr_i   = 6'($urandom_range(0, 63));
                    mel_value_i = 8'($urandom);
                    if (int'(mel_ptr_i) < NF) model[mel_ptr_i] = mel_value_i;
                end
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                    mel_valid_i = 1'b0;
                end
                idx = (i * 7 + 6) % NF;
                val = 8'($urandom);
            end else begin
                idx = i;
                val = 8'(i);
            end
            @(posedge clk);
            #1;
            mel_valid_i = 1'b1;
            mel_ptr_i   = 6'(idx);
            mel_value_i = val;
            mel_done_i  = coinc && (i == NF - 1);
            model[idx]  = val;
        end
        if (!coinc) begin
            @(posedge clk);
            #1;
            mel_valid_i = 1'b0;
            mel_done_i  = 1'b1;
        end
        for (int k = 0; k < NF; k++)
            exp_q.push_back('{data: model[k], idx: 6'(k), last: (k == NF - 1)});
        @(posedge clk);
        #1;
        mel_valid_i = 1'b0;
        mel_done_i  = 1'b0;
    endtask

    initial begin
        mel_valid_i = 1'b0;
        mel_done_i  = 1'b0;
        mel_value_i = '0;
        mel_ptr_i   = '0;
        forever begin
            @(posedge clk);
            #1;
            mel_valid_i = 1'b0;
            mel_done_i  = 1'b0;
            // Stray engine activity outside WAIT must be ignored.
            if (stray_en && $urandom_range(0, 3) == 0) begin
                mel_valid_i = 1'b1;
                mel_done_i  = 1'($urandom_range(0, 1));
                mel_ptr_i   = 6'($urandom_range(0, 63));
                mel_value_i = 8'($urandom);
            end
            @(negedge clk);
            if (mel_start_o) run_engine();
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer.
    initial begin
        wr_t w;
        en_t e;
        forever begin
            @(negedge clk);
            if (mel_start_o) start_cnt++;
            if (mel_in_valid_o) begin
                if (wr_q.size() == 0) begin
                    check("mel_wr_unexpected", mel_in_valid_o, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("mel_ptr", mel_ptr_o, w.ptr);
                    check("mel_data", mel_data_o, w.data);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("m_unexpected", m_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_idx", m_idx, e.idx);
                    check("m_last", m_last, e.last);
                end
            end
        end
    end

    task automatic send_frame(input int n, input int last_at, input bit idx_data, input bit clr_at_last);
        bit ok;
        if (n == NB) exp_starts++;
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            s_valid   = 1'b1;
            s_data    = idx_data ? 32'(b) : $urandom;
            s_last    = (b == last_at);
            err_clr_i = clr_at_last && (b == last_at);
            wr_q.push_back('{ptr: 9'(b), data: s_data});
            ok = 1'b0;
            for (int w = 0; w < 5000; w++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check("s_ready_wait", s_ready, 1);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "input stream stalled");
            end
            @(posedge clk);
            #1;
            s_valid   = 1'b0;
            s_last    = 1'b0;
            err_clr_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy_o && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle", {busy_o, exp_q.size() != 0}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        check("err_cleared", err_o, 0);
    endtask

    initial begin
        int  sb;
        bit  found;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        err_clr_i = 1'b0;

        // Outputs under reset, with live-looking input traffic.
        repeat (2) @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        s_last  = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_mel_in_valid", mel_in_valid_o, 0);
        check("rst_mel_ptr", mel_ptr_o, 0);
        check("rst_mel_data", mel_data_o, 0);
        check("rst_mel_start", mel_start_o, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("s_ready_after_edge", s_ready, 1);
        stray_en = 1'b1;

        // Index-valued frame, ordered energies, random back-pressure.
        eng_mode = 0;
        rdy_mode = 0;
        sb = start_cnt;
        send_frame(NB, NB - 1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("one_start_pulse", start_cnt, sb + 1);
        check("in_wait_busy", busy_o, 1);
        check("in_wait_no_mvalid", m_valid, 0);
        wait_idle();
        frames_model++;
        check("frame_cnt_f1", frame_cnt_o, frames_model);
        check("err_f1", err_o, 0);

        // Early s_last on beat 100.
        sb = start_cnt;
        send_frame(101, 100, 1'b0, 1'b0);
        check("early_last_err", err_o, 1);
        check("early_last_fill", busy_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("early_last_no_start", start_cnt, sb);
        clear_err();

        // Clean frame, done coincident with the idx-39 capture.
        eng_mode = 1;
        send_frame(NB, NB - 1, 1'b0, 1'b0);
        wait_idle();
        frames_model++;
        check("frame_cnt_f2", frame_cnt_o, frames_model);
        check("err_f2", err_o, 0);

        // Missing s_last on the final beat: flagged, frame still completes.
        eng_mode = 2;
        send_frame(NB, -1, 1'b0, 1'b0);
        check("missing_last_err", err_o, 1);
        wait_idle();
        frames_model++;
        check("frame_cnt_f3", frame_cnt_o, frames_model);
        clear_err();

        // Error set and clear in the same cycle: set wins.
        send_frame(11, 10, 1'b0, 1'b1);
        check("set_beats_clear", err_o, 1);
        clear_err();

        // Timeout: engine silent.
        eng_mode = 3;
        sb = start_cnt;
        send_frame(NB, NB - 1, 1'b0, 1'b0);
        @(negedge clk);
        repeat (TO) @(negedge clk);
        check("timeout_last_wait_cycle", busy_o, 1);
        check("timeout_not_early", err_o, 0);
        @(negedge clk);
        check("timeout_fill", busy_o, 0);
        check("timeout_err", err_o, 1);
        check("timeout_no_mvalid", m_valid, 0);
        check("timeout_frame_cnt", frame_cnt_o, frames_model);
        check("timeout_start", start_cnt, sb + 1);
        @(posedge clk);
        #1;
        clear_err();

        // Reset in the middle of DRAIN.
        eng_mode = 2;
        rdy_mode = 1;
        send_frame(NB, NB - 1, 1'b0, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (m_valid && m_idx == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        check("drain_reached_idx20", found, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_frame_cnt", frame_cnt_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_s_ready", s_ready, 0);
        check("mid_rst_err", err_o, 0);
        exp_q.delete();
        frames_model = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", s_ready, 1);
        rdy_mode = 0;
        send_frame(NB, NB - 1, 1'b0, 1'b0);
        wait_idle();
        frames_model++;
        check("post_rst_frame_cnt", frame_cnt_o, frames_model);

        // Randomised frames.
        for (int k = 0; k < 3; k++) begin
            eng_mode = $urandom_range(1, 2);
            rdy_mode = $urandom_range(0, 1);
            send_frame(NB, NB - 1, 1'b0, 1'b0);
            wait_idle();
            frames_model++;
            check("rand_frame_cnt", frame_cnt_o, frames_model);
            check("rand_err", err_o, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_drained", wr_q.size(), 0);
        check("exp_queue_drained", exp_q.size(), 0);
        check("start_pulses_total", start_cnt, exp_starts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mel_frame_scheduler.md
MEL_FRAME_SCHEDULER -- requirements
Module: mel_frame_scheduler

Interface
REQ-001 Parameter NUM_FILTERS, default 40: number of mel filter outputs per frame.
REQ-002 Parameter NRFFT, default 257: power-spectrum bins per frame.
REQ-003 Parameter INPUT_WIDTH, default 32: power-spectrum sample width.
REQ-004 Parameter OUTPUT_WIDTH, default 8: mel energy width.
REQ-005 Parameter TIMEOUT, default 16384: maximum WAIT cycles before abort.
REQ-006 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  spectrum beat valid.
- s_ready  out  1  spectrum beat accepted.
- s_data  in  INPUT_WIDTH  spectrum sample.
- s_last  in  1  final bin of frame.
- mel_in_valid_o  out  1  write strobe to mel buffer.
- mel_ptr_o  out  clog2(NRFFT)  bin index.
- mel_data_o  out  INPUT_WIDTH  bin value.
- mel_start_o  out  1  mel computation start pulse.
- mel_done_i  in  1  mel computation finished.
- mel_valid_i  in  1  mel energy qualifier.
- mel_value_i  in  OUTPUT_WIDTH  mel energy.
- mel_ptr_i  in  clog2(NUM_FILTERS)  energy filter index.
- m_valid  out  1  energy out valid.
- m_ready  in  1  downstream ready.
- m_data  out  OUTPUT_WIDTH  energy.
- m_idx  out  clog2(NUM_FILTERS)  filter index.
- m_last  out  1  final energy of frame.
- busy_o  out  1  high outside FILL.
- err_o  out  1  sticky error.
- err_clr_i  in  1  clears err_o.
- frame_cnt_o  out  16  completed frames, wraps.

Function
REQ-007 FSM states SHALL be FILL, START, WAIT and DRAIN, in that order, with DRAIN returning to FILL.
REQ-008 FILL: s_ready=1; each handshake (s_valid&s_ready) SHALL drive mel_in_valid_o=1, mel_ptr_o=beat counter and mel_data_o=s_data in the same cycle, with zero latency.
REQ-009 FILL: the beat counter SHALL increment per handshake and, after beat NRFFT-1, reset to 0 with transition to START.
REQ-010 s_last on a beat other than NRFFT-1 SHALL set err_o, reset the beat counter and remain in FILL.
REQ-011 Missing s_last on beat NRFFT-1 SHALL set err_o, and the frame SHALL proceed.
REQ-012 START: mel_start_o=1 for exactly one cycle, all energy buffer valid flags SHALL clear, then the FSM moves to WAIT.
REQ-013 WAIT: when mel_valid_i=1 and mel_ptr_i<NUM_FILTERS, mel_value_i SHALL be written to buffer[mel_ptr_i]; the last write per index wins.
REQ-014 WAIT: mel_done_i=1 SHALL transition to DRAIN; a capture in that same cycle SHALL still be written.
REQ-015 WAIT: the cycle counter reaching TIMEOUT SHALL set err_o and return to FILL without output.
REQ-016 mel_done_i and mel_valid_i SHALL be ignored outside WAIT.
REQ-017 DRAIN: m_valid=1, m_idx=drain index, m_data=buffer[m_idx], m_last=(m_idx==NUM_FILTERS-1).
REQ-018 DRAIN: outputs SHALL hold stable while m_ready=0; the index SHALL advance on m_valid&m_ready.
REQ-019 DRAIN: the final handshake SHALL increment frame_cnt_o (modulo 2^16) and return to FILL.
REQ-020 s_ready, mel_in_valid_o, mel_start_o and m_valid SHALL be 0 in every state other than the one defining them.
REQ-021 err_o SHALL be cleared by err_clr_i; a same-cycle set SHALL win over the clear.
REQ-022 busy_o SHALL equal (state != FILL).

Reset
REQ-023 Asserting rst_n low SHALL immediately force state FILL, zero all counters, frame_cnt_o=0 and err_o=0, including mid-frame.
REQ-024 All outputs SHALL be 0 while rst_n is low; s_ready SHALL be registered and rise on the first clk edge after release.
REQ-025 Energy buffer contents SHALL NOT require reset.

Verification
REQ-026 Scenario: 257 beats with data=bin index and s_last on beat 256 -> ptr 0..256 mirrored, one mel_start_o pulse, FSM in WAIT.
REQ-027 Scenario: model returns energies 0..39 then done, m_ready toggling 50% -> m_data 0..39 in order, m_last at idx 39, frame_cnt_o=1.
REQ-028 Scenario: s_last on beat 100 -> err_o=1, no start pulse; a following clean 257-beat frame completes normally.
REQ-029 Scenario: no mel_done_i for TIMEOUT cycles -> err_o=1, back to FILL, no m_valid; err_clr_i clears err_o.
REQ-030 Scenario: mel_done_i coincident with capture of idx 39 -> value captured and output at idx 39.
REQ-031 Scenario: rst_n low during DRAIN at idx 20 -> m_valid=0 immediately, frame_cnt_o=0, FILL accepts a new frame.
